// File: rtl/fpu_issue.sv
// Issue/sequencing stage in front of the FP datapath: holds one op on the fpu
// inputs for its latency, captures the result and offers it to writeback.
// Optional macro FPU_ISSUE_PIPE_EN lets a new op be accepted on the result handoff edge.
module fpu_issue #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 10,
  parameter int LAT_DEF  = 1,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_x1,
  input  logic [31:0] in_x2,
  output logic [2:0]  fpu_funct3,
  output logic [6:0]  fpu_funct7,
  output logic [31:0] fpu_x1,
  output logic [31:0] fpu_x2,
  input  logic [31:0] fpu_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    funct3_r;
  logic [6:0]    funct7_r;
  logic [31:0]   x1_r;
  logic [31:0]   x2_r;
  logic [4:0]    rd_r;
  logic          out_valid_r;
  logic [4:0]    out_rd_r;
  logic [31:0]   out_y_r;
  logic          accept_s;
  logic          capture_s;
  logic          handoff_s;

  // A zero latency would never reach the capture count, so clamp it to one cycle.
  function automatic logic [CW-1:0] lat_of(input logic [6:0] f7);
    int l;
    case (f7)
      7'h00, 7'h04: l = LAT_ADD;
      7'h08:        l = LAT_MUL;
      7'h0C:        l = LAT_DIV;
      7'h2C:        l = LAT_SQRT;
      default:      l = LAT_DEF;
    endcase
    return (l < 1) ? CW'(1) : CW'(l);
  endfunction

`ifdef FPU_ISSUE_PIPE_EN
  assign in_ready = (state_r == IDLE) | ((state_r == DONE) & out_ready);
`else
  assign in_ready = (state_r == IDLE);
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and accept/capture/handoff strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    handoff_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r <= CW'(1)) begin
          capture_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          handoff_s = 1'b1;
`ifdef FPU_ISSUE_PIPE_EN
          if (in_valid) begin
            accept_s    = 1'b1;
            state_nxt_s = BUSY;
          end else begin
            state_nxt_s = IDLE;
          end
`else
          state_nxt_s = IDLE;
`endif
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand hold registers and latency counter; operands only change on accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      funct3_r <= 3'd0;
      funct7_r <= 7'd0;
      x1_r     <= 32'd0;
      x2_r     <= 32'd0;
      rd_r     <= 5'd0;
      cnt_r    <= '0;
    end else if (accept_s) begin
      funct3_r <= in_funct3;
      funct7_r <= in_funct7;
      x1_r     <= in_x1;
      x2_r     <= in_x2;
      rd_r     <= in_rd;
      cnt_r    <= lat_of(in_funct7);
    end else if ((state_r == BUSY) && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CW'(1);
    end
  end

  // Result capture and writeback handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      out_rd_r    <= 5'd0;
      out_y_r     <= 32'd0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      out_rd_r    <= rd_r;
      out_y_r     <= fpu_y;
    end else if (handoff_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign fpu_funct3 = funct3_r;
  assign fpu_funct7 = funct7_r;
  assign fpu_x1     = x1_r;
  assign fpu_x2     = x2_r;
  assign out_valid  = out_valid_r;
  assign out_rd     = out_rd_r;
  assign out_y      = out_y_r;

endmodule
